// File: rtl/rf_corr_pkg.sv
// Shared types and constants for the RF correlation scheduler.
package rf_corr_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIssue   = 2'd1,
    StWait    = 2'd2,
    StDeliver = 2'd3
  } sched_state_e;

  localparam int unsigned FrameWDefault = 32;
  localparam int unsigned ResWDefault   = 4;

  // Match index reported to a channel whose correlation was aborted.
  localparam logic [ResWDefault-1:0] TimeoutResult = '1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester searching upward from ptr+1.
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] idx
);

  logic            found;
  logic [IdxW-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = IdxW'((32'(ptr) + i) % N);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/rf_corr_scheduler.sv
// Shares one correlator between NUM_CH channels with round-robin grants.
// Optional WAIT timeout enabled by defining RF_SCHED_TIMEOUT_EN.
module rf_corr_scheduler
  import rf_corr_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned FRAME_W     = FrameWDefault,
  parameter int unsigned RES_W       = ResWDefault,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic [NUM_CH-1:0]         req,
  input  logic [NUM_CH*FRAME_W-1:0] frame_in,
  output logic [NUM_CH-1:0]         ack,
  output logic                      corr_start,
  output logic [FRAME_W-1:0]        corr_frame,
  input  logic                      corr_done,
  input  logic [RES_W-1:0]          corr_result,
  output logic [NUM_CH-1:0]         res_valid,
  output logic [RES_W-1:0]          res_data,
  output logic                      busy,
  output logic                      err_timeout
);

  localparam int unsigned IdxW = $clog2(NUM_CH);
  localparam logic [RES_W-1:0] TimeoutRes = {RES_W{&TimeoutResult}};

  sched_state_e      state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d, gidx_q, gidx_d;
  logic [NUM_CH-1:0] ack_q, ack_d, res_valid_q, res_valid_d;
  logic              start_q, start_d, err_q, err_d, busy_q;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [RES_W-1:0]  res_q, res_d;
  logic [NUM_CH-1:0] arb_gnt;
  logic [IdxW-1:0]   arb_idx;
  logic              timeout_hit;

  rr_arbiter #(
    .N    (NUM_CH),
    .IdxW (IdxW)
  ) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

`ifdef RF_SCHED_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  logic [CntW-1:0] cnt_q;

  // Counts completed WAIT cycles; expiry lands on the TIMEOUT_CYC-th one.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else if (state_q == StWait) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end

  assign timeout_hit = (state_q == StWait) && (cnt_q == CntW'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign timeout_hit        = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gidx_d      = gidx_q;
    frame_d     = frame_q;
    res_d       = res_q;
    ack_d       = '0;
    start_d     = 1'b0;
    res_valid_d = '0;
    err_d       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          gidx_d  = arb_idx;
          frame_d = frame_in[arb_idx*FRAME_W +: FRAME_W];
          ack_d   = arb_gnt;
          start_d = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        // A done arriving on the expiry edge still delivers a normal result.
        if (corr_done) begin
          res_d               = corr_result;
          res_valid_d[gidx_q] = 1'b1;
          state_d             = StDeliver;
        end else if (timeout_hit) begin
          res_d               = TimeoutRes;
          res_valid_d[gidx_q] = 1'b1;
          err_d               = 1'b1;
          state_d             = StDeliver;
        end
      end
      StDeliver: begin
        ptr_d   = gidx_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= StIdle;
      ptr_q       <= IdxW'(NUM_CH - 1);
      gidx_q      <= '0;
      frame_q     <= '0;
      res_q       <= '0;
      ack_q       <= '0;
      start_q     <= 1'b0;
      res_valid_q <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gidx_q      <= gidx_d;
      frame_q     <= frame_d;
      res_q       <= res_d;
      ack_q       <= ack_d;
      start_q     <= start_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
      busy_q      <= (state_d != StIdle);
    end
  end

  assign ack         = ack_q;
  assign corr_start  = start_q;
  assign corr_frame  = frame_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_rf_corr_scheduler.sv
// Randomized self-checking bench for rf_corr_scheduler against a transaction-level model.
module tb_rf_corr_scheduler;

  localparam int NUM_CH  = 4;
  localparam int FRAME_W = 32;
  localparam int RES_W   = 4;

  logic                      Clock = 1'b0;
  logic                      Reset;
  logic [NUM_CH-1:0]         req;
  logic [NUM_CH*FRAME_W-1:0] frame_in;
  logic [NUM_CH-1:0]         ack;
  logic                      corr_start;
  logic [FRAME_W-1:0]        corr_frame;
  logic                      corr_done;
  logic [RES_W-1:0]          corr_result;
  logic [NUM_CH-1:0]         res_valid;
  logic [RES_W-1:0]          res_data;
  logic                      busy;
  logic                      err_timeout;

  logic [FRAME_W-1:0] frames [NUM_CH];
  int tests = 0;
  int fails = 0;
  int ptr_m;
  logic [RES_W-1:0] last_res;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_frames
    assign frame_in[i*FRAME_W +: FRAME_W] = frames[i];
  end

  rf_corr_scheduler #(
    .NUM_CH      (NUM_CH),
    .FRAME_W     (FRAME_W),
    .RES_W       (RES_W),
    .TIMEOUT_CYC (8)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .req         (req),
    .frame_in    (frame_in),
    .ack         (ack),
    .corr_start  (corr_start),
    .corr_frame  (corr_frame),
    .corr_done   (corr_done),
    .corr_result (corr_result),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_CH-1:0] oh(input int g);
    logic [NUM_CH-1:0] v;
    v    = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  // Model of the fairness rule: first requester after the last served channel.
  function automatic int pick(input logic [NUM_CH-1:0] m, input int p);
    for (int k = 1; k <= NUM_CH; k++) begin
      if (m[(p + k) % NUM_CH]) return (p + k) % NUM_CH;
    end
    return -1;
  endfunction

  // One full transaction starting from IDLE with req already driven.
  task automatic run_txn(input int lat, input logic [RES_W-1:0] result,
                         input bit spur, input bit keep);
    int g;
    logic [FRAME_W-1:0] exp_frame;
    g = pick(req, ptr_m);
    check("model_has_request", 64'(g >= 0), 64'd1);
    if (g < 0) return;
    exp_frame = frames[g];
    tick();
    check("grant_ack", 64'(ack), 64'(oh(g)));
    check("grant_start", 64'(corr_start), 64'd1);
    check("grant_frame", 64'(corr_frame), 64'(exp_frame));
    check("grant_busy", 64'(busy), 64'd1);
    if (keep) frames[g] = $urandom();
    else req[g] = 1'b0;
    if (spur) begin
      corr_done   = 1'b1;
      corr_result = ~result;
    end
    tick();
    corr_done = 1'b0;
    check("issue_ack_clear", 64'(ack), 64'd0);
    check("issue_start_clear", 64'(corr_start), 64'd0);
    check("issue_no_result", 64'(res_valid), 64'd0);
    repeat (lat - 1) tick();
    check("wait_frame_stable", 64'(corr_frame), 64'(exp_frame));
    check("wait_busy", 64'(busy), 64'd1);
    corr_done   = 1'b1;
    corr_result = result;
    tick();
    corr_done   = 1'b0;
    corr_result = RES_W'($urandom());
    check("deliver_valid", 64'(res_valid), 64'(oh(g)));
    check("deliver_data", 64'(res_data), 64'(result));
    check("deliver_no_err", 64'(err_timeout), 64'd0);
    tick();
    check("idle_valid_clear", 64'(res_valid), 64'd0);
    check("idle_busy_low", 64'(busy), 64'd0);
    check("idle_data_hold", 64'(res_data), 64'(result));
    last_res = result;
    ptr_m    = g;
  endtask

  initial begin
    Reset       = 1'b1;
    req         = '0;
    corr_done   = 1'b0;
    corr_result = '0;
    for (int i = 0; i < NUM_CH; i++) frames[i] = $urandom();
    ptr_m    = NUM_CH - 1;
    last_res = '0;
    repeat (2) tick();
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_start", 64'(corr_start), 64'd0);
    check("rst_frame", 64'(corr_frame), 64'd0);
    check("rst_valid", 64'(res_valid), 64'd0);
    check("rst_data", 64'(res_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err_timeout), 64'd0);
    Reset = 1'b0;
    tick();

    // Single request from channel 2, done three cycles after start.
    frames[2] = 32'hA5A5_0F0F;
    req       = 4'b0100;
    run_txn(3, 4'h9, 1'b0, 1'b0);

    // Reset in WAIT with a late done afterwards.
    req = 4'b0010;
    tick();
    check("rstw_grant", 64'(ack), 64'(oh(pick(4'b0010, ptr_m))));
    req = '0;
    tick();
    tick();
    Reset = 1'b1;
    #1;
    check("rstw_busy", 64'(busy), 64'd0);
    check("rstw_frame", 64'(corr_frame), 64'd0);
    check("rstw_data", 64'(res_data), 64'd0);
    tick();
    Reset = 1'b0;
    ptr_m    = NUM_CH - 1;
    last_res = '0;
    tick();
    tick();
    corr_done   = 1'b1;
    corr_result = 4'h6;
    tick();
    corr_done = 1'b0;
    check("rstw_late_done_valid", 64'(res_valid), 64'd0);
    check("rstw_late_done_busy", 64'(busy), 64'd0);
    check("rstw_late_done_data", 64'(res_data), 64'd0);

    // All channels requesting continuously: expect 0,1,2,3,0.
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      check("rr_order", 64'(pick(req, ptr_m)), 64'(n % NUM_CH));
      run_txn(1, RES_W'($urandom()), 1'b0, 1'b1);
    end

    // Channels 1 and 3 alternate.
    req = 4'b1010;
    for (int n = 0; n < 4; n++) run_txn(1 + n, RES_W'($urandom()), 1'b0, 1'b1);

    // Spurious done in IDLE, then one during ISSUE.
    req         = '0;
    corr_done   = 1'b1;
    corr_result = 4'h7;
    tick();
    corr_done = 1'b0;
    check("spur_idle_valid", 64'(res_valid), 64'd0);
    check("spur_idle_busy", 64'(busy), 64'd0);
    check("spur_idle_data", 64'(res_data), 64'(last_res));
    req = 4'b0001;
    run_txn(2, 4'hC, 1'b1, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 25; n++) begin
      req = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
      run_txn($urandom_range(1, 5), RES_W'($urandom()), ($urandom() % 4) == 0,
              $urandom() % 2 == 1);
    end

    // Correlator never answers.
    req = 4'b0100;
    tick();
    req = '0;
    tick();
`ifdef RF_SCHED_TIMEOUT_EN
    repeat (7) tick();
    check("to_not_yet", 64'(res_valid), 64'd0);
    tick();
    check("to_err", 64'(err_timeout), 64'd1);
    check("to_valid", 64'(res_valid), 64'(oh(pick(4'b0100, ptr_m))));
    check("to_data", 64'(res_data), 64'hF);
    tick();
    check("to_err_clear", 64'(err_timeout), 64'd0);
    check("to_idle", 64'(busy), 64'd0);
`else
    repeat (100) tick();
    check("nto_busy", 64'(busy), 64'd1);
    check("nto_err", 64'(err_timeout), 64'd0);
    check("nto_valid", 64'(res_valid), 64'd0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
    check("nto_recover", 64'(busy), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
